// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Executes one RV32I load or store at a time for the access-mem reservation
//   station. An issued op computes its effective address, then either raises a
//   single word-aligned data-memory request (held until acknowledged) or, if the
//   address is misaligned for the access width, skips memory and reports a
//   misalignment. Every op ends with a one-cycle result pulse.
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   issue_valid_i/ready_o     issue handshake (ready only while idle)
//   pc_i, src_op_1_i, imm_i   op pc, base register, immediate offset
//   src_op_2_i                store data
//   rrf_tag_i, dst_val_i      rename tag and destination-valid of the op
//   is_store_i, funct3_i      store flag and RV32I width/sign code
//   dmem_req_o/we_o/addr_o    data-memory request, write enable, word address
//   dmem_wdata_o/wstrb_o      lane-replicated store data and byte strobes
//   dmem_ack_i, dmem_rdata_i  request completion and word-aligned read data
//   result_*                  one-cycle completion: data, tag, dst valid, pc
//   misalign_o                completion was a misaligned access
module mem_access_unit #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32,
    parameter int RRF_SEL  = 6
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                issue_valid_i,
    input  logic [ADDR_LEN-1:0] pc_i,
    input  logic [DATA_LEN-1:0] src_op_1_i,
    input  logic [DATA_LEN-1:0] src_op_2_i,
    input  logic [DATA_LEN-1:0] imm_i,
    input  logic [RRF_SEL-1:0]  rrf_tag_i,
    input  logic                dst_val_i,
    input  logic                is_store_i,
    input  logic [2:0]          funct3_i,
    output logic                issue_ready_o,
    output logic                dmem_req_o,
    output logic                dmem_we_o,
    output logic [ADDR_LEN-1:0] dmem_addr_o,
    output logic [DATA_LEN-1:0] dmem_wdata_o,
    output logic [3:0]          dmem_wstrb_o,
    input  logic                dmem_ack_i,
    input  logic [DATA_LEN-1:0] dmem_rdata_i,
    output logic                result_valid_o,
    output logic [DATA_LEN-1:0] result_o,
    output logic [RRF_SEL-1:0]  result_rrf_tag_o,
    output logic                result_dst_val_o,
    output logic [ADDR_LEN-1:0] result_pc_o,
    output logic                misalign_o
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Access width: reserved encodings (x11, and stores with bit 2 set)
    // fall back to a full word.
    function automatic logic [1:0] eff_size(input logic [2:0] f3, input logic st);
        if ((f3[1:0] == 2'b11) || (st && f3[2]))
            return SZ_WORD;
        return f3[1:0];
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        return ((size == SZ_HALF) && lo[0]) || ((size == SZ_WORD) && (lo != 2'b00));
    endfunction

    function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] strb;
        case (size)
            SZ_BYTE: strb = 4'b0001 << lo;
            SZ_HALF: strb = 4'b0011 << lo;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Replicating the operand across lanes lets the strobes pick the lane.
    function automatic logic [DATA_LEN-1:0] store_data(input logic [1:0] size,
                                                       input logic [DATA_LEN-1:0] d);
        case (size)
            SZ_BYTE: return {4{d[7:0]}};
            SZ_HALF: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [DATA_LEN-1:0] load_extend(input logic [1:0] size,
                                                        input logic uns,
                                                        input logic [1:0] lo,
                                                        input logic [DATA_LEN-1:0] rdata);
        logic [DATA_LEN-1:0] sh;
        sh = rdata >> {lo, 3'b000};
        case (size)
            SZ_BYTE: return uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: return uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    state_t               state;
    logic [1:0]           size_q;
    logic [1:0]           lo_q;
    logic                 store_q;
    logic                 uns_q;
    logic                 dst_val_q;
    logic [RRF_SEL-1:0]   tag_q;
    logic [ADDR_LEN-1:0]  pc_q;

    logic [DATA_LEN-1:0]  addr_calc;
    logic [1:0]           size_calc;
    logic                 mis_calc;
    logic                 accept;

    assign addr_calc     = src_op_1_i + imm_i;
    assign size_calc     = eff_size(funct3_i, is_store_i);
    assign mis_calc      = is_misaligned(size_calc, addr_calc[1:0]);
    assign issue_ready_o = (state == IDLE);
    assign accept        = issue_valid_i && issue_ready_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state            <= IDLE;
            size_q           <= '0;
            lo_q             <= '0;
            store_q          <= 1'b0;
            uns_q            <= 1'b0;
            dst_val_q        <= 1'b0;
            tag_q            <= '0;
            pc_q             <= '0;
            dmem_req_o       <= 1'b0;
            dmem_we_o        <= 1'b0;
            dmem_addr_o      <= '0;
            dmem_wdata_o     <= '0;
            dmem_wstrb_o     <= '0;
            result_valid_o   <= 1'b0;
            result_o         <= '0;
            result_rrf_tag_o <= '0;
            result_dst_val_o <= 1'b0;
            result_pc_o      <= '0;
            misalign_o       <= 1'b0;
        end else begin
            case (state)
                // Issue: latch the op, then either go to memory or report
                // the misalignment straight away.
                IDLE: begin
                    if (accept) begin
                        tag_q     <= rrf_tag_i;
                        pc_q      <= pc_i;
                        dst_val_q <= dst_val_i;
                        store_q   <= is_store_i;
                        size_q    <= size_calc;
                        uns_q     <= ~is_store_i & funct3_i[2];
                        lo_q      <= addr_calc[1:0];
                        if (mis_calc) begin
                            state            <= RESP;
                            result_valid_o   <= 1'b1;
                            misalign_o       <= 1'b1;
                            result_o         <= '0;
                            result_dst_val_o <= 1'b0;
                            result_rrf_tag_o <= rrf_tag_i;
                            result_pc_o      <= pc_i;
                        end else begin
                            state        <= REQ;
                            dmem_req_o   <= 1'b1;
                            dmem_we_o    <= is_store_i;
                            dmem_addr_o  <= {addr_calc[ADDR_LEN-1:2], 2'b00};
                            dmem_wstrb_o <= is_store_i ? store_strb(size_calc, addr_calc[1:0]) : 4'b0000;
                            dmem_wdata_o <= is_store_i ? store_data(size_calc, src_op_2_i) : '0;
                        end
                    end
                end
                // Memory: request held unchanged until acknowledged.
                REQ: begin
                    if (dmem_ack_i) begin
                        state            <= RESP;
                        dmem_req_o       <= 1'b0;
                        dmem_we_o        <= 1'b0;
                        dmem_wstrb_o     <= 4'b0000;
                        result_valid_o   <= 1'b1;
                        misalign_o       <= 1'b0;
                        result_o         <= store_q ? '0 : load_extend(size_q, uns_q, lo_q, dmem_rdata_i);
                        result_dst_val_o <= dst_val_q & ~store_q;
                        result_rrf_tag_o <= tag_q;
                        result_pc_o      <= pc_q;
                    end
                end
                // Completion: single-cycle pulse; result data stays held.
                RESP: begin
                    state          <= IDLE;
                    result_valid_o <= 1'b0;
                    misalign_o     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        issue_valid_i;
    logic [31:0] pc_i;
    logic [31:0] src_op_1_i;
    logic [31:0] src_op_2_i;
    logic [31:0] imm_i;
    logic [5:0]  rrf_tag_i;
    logic        dst_val_i;
    logic        is_store_i;
    logic [2:0]  funct3_i;
    logic        issue_ready_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_wstrb_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        result_valid_o;
    logic [31:0] result_o;
    logic [5:0]  result_rrf_tag_o;
    logic        result_dst_val_o;
    logic [31:0] result_pc_o;
    logic        misalign_o;

    mem_access_unit #(.ADDR_LEN(32), .DATA_LEN(32), .RRF_SEL(6)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .issue_valid_i(issue_valid_i),
        .pc_i(pc_i), .src_op_1_i(src_op_1_i), .src_op_2_i(src_op_2_i),
        .imm_i(imm_i), .rrf_tag_i(rrf_tag_i), .dst_val_i(dst_val_i),
        .is_store_i(is_store_i), .funct3_i(funct3_i), .issue_ready_o(issue_ready_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .result_valid_o(result_valid_o), .result_o(result_o),
        .result_rrf_tag_o(result_rrf_tag_o), .result_dst_val_o(result_dst_val_o),
        .result_pc_o(result_pc_o), .misalign_o(misalign_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  f3;
        logic        st;
        logic [31:0] base;
        logic [31:0] imm;
        logic [31:0] data;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic [5:0]  tag;
        logic        dv;
        int          delay;
        logic        er;
        logic [31:0] eaddr;
        logic [3:0]  estrb;
        logic [31:0] ewdata;
        logic [31:0] eres;
        int          elat;
        logic        emis;
        logic        edst;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] f3, input logic st,
                                input logic [31:0] base, input logic [31:0] imm,
                                input logic [31:0] data, input logic [31:0] rdata,
                                input int delay, input logic er, input logic [31:0] eaddr,
                                input logic [3:0] estrb, input logic [31:0] ewdata,
                                input logic [31:0] eres, input int elat,
                                input logic emis, input logic edst, input int idx);
        vec_t v;
        v.f3 = f3; v.st = st; v.base = base; v.imm = imm; v.data = data;
        v.rdata = rdata; v.delay = delay; v.er = er; v.eaddr = eaddr;
        v.estrb = estrb; v.ewdata = ewdata; v.eres = eres; v.elat = elat;
        v.emis = emis; v.edst = edst; v.dv = 1'b1;
        v.tag = 6'(idx + 1);
        v.pc = 32'h8000_0000 + 32'(idx * 4);
        return v;
    endfunction

    // Reference model: access width in bytes, alignment by remainder,
    // lane extraction by division and sign fix-up by subtraction.
    function automatic vec_t model(input vec_t v);
        logic [31:0] a;
        int lo, nb;
        bit sgn;
        longint val;
        a  = v.base + v.imm;
        lo = int'(a % 32'd4);
        if (v.st) nb = (v.f3 == 3'd0) ? 1 : (v.f3 == 3'd1) ? 2 : 4;
        else      nb = (v.f3 == 3'd0 || v.f3 == 3'd4) ? 1 : (v.f3 == 3'd1 || v.f3 == 3'd5) ? 2 : 4;
        sgn    = !v.st && (v.f3 == 3'd0 || v.f3 == 3'd1);
        v.emis = (lo % nb) != 0;
        v.er   = !v.emis;
        v.eaddr = a - 32'(lo);
        v.estrb = 4'b0000;
        if (v.st)
            for (int i = lo; i < lo + nb && i < 4; i++) v.estrb[i] = 1'b1;
        if (nb == 1)      v.ewdata = (v.data & 32'hFF) * 32'h0101_0101;
        else if (nb == 2) v.ewdata = (v.data & 32'hFFFF) * 32'h0001_0001;
        else              v.ewdata = v.data;
        v.eres = 32'd0;
        if (!v.st && !v.emis) begin
            val = longint'({32'd0, v.rdata}) / (longint'(1) << (8 * lo));
            val = val % (longint'(1) << (8 * nb));
            if (sgn && val >= (longint'(1) << (8 * nb - 1))) val = val - (longint'(1) << (8 * nb));
            v.eres = val[31:0];
        end
        v.elat = v.emis ? 1 : v.delay + 2;
        v.edst = v.dv && !v.st && !v.emis;
        return v;
    endfunction

    // Issue one op from an idle unit, act as the memory, and compare the
    // whole transaction. Entered and left #1 after a rising edge.
    task automatic apply_vec(input vec_t v, input bit noise, input string tn);
        logic [31:0] a_addr, a_wdata, r_res, r_pc;
        logic [3:0]  a_strb;
        logic [5:0]  r_tag;
        logic        a_we, r_mis, r_dst;
        int req_n, pulses, lat;
        bit stable_err, ready_err, done;
        a_addr = 0; a_wdata = 0; a_strb = 0; a_we = 0;
        r_res = 0; r_pc = 0; r_tag = 0; r_mis = 0; r_dst = 0;
        req_n = 0; pulses = 0; lat = 0; stable_err = 0; ready_err = 0; done = 0;

        check({tn, ".ready_idle"}, 32'(issue_ready_o), 32'd1);
        src_op_1_i = v.base; imm_i = v.imm; src_op_2_i = v.data; funct3_i = v.f3;
        is_store_i = v.st; rrf_tag_i = v.tag; pc_i = v.pc; dst_val_i = v.dv;
        issue_valid_i = 1'b1;
        @(posedge clk_i); #1;
        issue_valid_i = 1'b0;
        src_op_1_i = $urandom; imm_i = $urandom; src_op_2_i = $urandom;
        funct3_i = 3'($urandom); is_store_i = 1'($urandom); rrf_tag_i = 6'($urandom);
        pc_i = $urandom; dst_val_i = 1'($urandom);

        for (int c = 1; c <= 30 && !done; c++) begin
            if (result_valid_o) begin
                pulses++;
                if (pulses == 1) begin
                    lat = c; r_res = result_o; r_mis = misalign_o; r_dst = result_dst_val_o;
                    r_tag = result_rrf_tag_o; r_pc = result_pc_o;
                end
            end else if (pulses > 0) begin
                check({tn, ".ready_after"}, 32'(issue_ready_o), 32'd1);
                check({tn, ".result_hold"}, result_o, r_res);
                check({tn, ".misalign_low"}, 32'(misalign_o), 32'd0);
                done = 1;
            end
            if (!done) begin
                if (issue_ready_o) ready_err = 1;
                if (dmem_req_o) begin
                    if (req_n == 0) begin
                        a_addr = dmem_addr_o; a_wdata = dmem_wdata_o; a_strb = dmem_wstrb_o; a_we = dmem_we_o;
                    end else if (a_addr !== dmem_addr_o || a_wdata !== dmem_wdata_o ||
                                 a_strb !== dmem_wstrb_o || a_we !== dmem_we_o) begin
                        stable_err = 1;
                    end
                    req_n++;
                    dmem_ack_i   = (req_n > v.delay);
                    dmem_rdata_i = dmem_ack_i ? v.rdata : $urandom;
                end else begin
                    dmem_ack_i   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                    dmem_rdata_i = $urandom;
                end
                @(posedge clk_i); #1;
            end
        end
        dmem_ack_i = 1'b0;

        check({tn, ".req_seen"}, 32'(req_n > 0), 32'(v.er));
        if (v.er) begin
            check({tn, ".req_cycles"}, 32'(req_n), 32'(v.delay + 1));
            check({tn, ".addr"}, a_addr, v.eaddr);
            check({tn, ".we"}, 32'(a_we), 32'(v.st));
            check({tn, ".wstrb"}, 32'(a_strb), 32'(v.estrb));
            if (v.st) check({tn, ".wdata"}, a_wdata, v.ewdata);
            check({tn, ".req_stable"}, 32'(stable_err), 32'd0);
        end
        check({tn, ".pulses"}, 32'(pulses), 32'd1);
        check({tn, ".latency"}, 32'(lat), 32'(v.elat));
        check({tn, ".result"}, r_res, v.eres);
        check({tn, ".misalign"}, 32'(r_mis), 32'(v.emis));
        check({tn, ".dst_val"}, 32'(r_dst), 32'(v.edst));
        check({tn, ".tag"}, 32'(r_tag), 32'(v.tag));
        check({tn, ".pc"}, r_pc, v.pc);
        check({tn, ".ready_busy"}, 32'(ready_err), 32'd0);
    endtask

    vec_t tbl[15];
    vec_t rv;
    bit   seen;

    initial begin
        reset_i = 1'b1; issue_valid_i = 1'b0; pc_i = 0; src_op_1_i = 0; src_op_2_i = 0;
        imm_i = 0; rrf_tag_i = 0; dst_val_i = 0; is_store_i = 0; funct3_i = 0;
        dmem_ack_i = 1'b0; dmem_rdata_i = 0;

        //          f3    st    base           imm          data           rdata         dly er  eaddr         strb     wdata          result        lat mis dst idx
        tbl[0]  = mk(3'd2, 1'b0, 32'h100,       32'h4,       32'h0,         32'hDEADBEEF, 0, 1, 32'h104,      4'b0000, 32'h0,         32'hDEADBEEF, 2, 0, 1, 0);
        tbl[1]  = mk(3'd0, 1'b0, 32'h200,       32'h3,       32'h0,         32'h80AABBCC, 0, 1, 32'h200,      4'b0000, 32'h0,         32'hFFFFFF80, 2, 0, 1, 1);
        tbl[2]  = mk(3'd4, 1'b0, 32'h200,       32'h3,       32'h0,         32'h80AABBCC, 0, 1, 32'h200,      4'b0000, 32'h0,         32'h00000080, 2, 0, 1, 2);
        tbl[3]  = mk(3'd1, 1'b1, 32'h300,       32'h2,       32'h1234ABCD,  32'h0,        0, 1, 32'h300,      4'b1100, 32'hABCDABCD,  32'h0,        2, 0, 0, 3);
        tbl[4]  = mk(3'd2, 1'b0, 32'h100,       32'h1,       32'h0,         32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,         32'h0,        1, 1, 0, 4);
        tbl[5]  = mk(3'd2, 1'b0, 32'h400,       32'h0,       32'h0,         32'h11223344, 3, 1, 32'h400,      4'b0000, 32'h0,         32'h11223344, 5, 0, 1, 5);
        tbl[6]  = mk(3'd0, 1'b1, 32'h500,       32'h1,       32'h000000A5,  32'h0,        1, 1, 32'h500,      4'b0010, 32'hA5A5A5A5,  32'h0,        3, 0, 0, 6);
        tbl[7]  = mk(3'd1, 1'b0, 32'h600,       32'h2,       32'h0,         32'h80010000, 0, 1, 32'h600,      4'b0000, 32'h0,         32'hFFFF8001, 2, 0, 1, 7);
        tbl[8]  = mk(3'd5, 1'b0, 32'h600,       32'h2,       32'h0,         32'h80010000, 0, 1, 32'h600,      4'b0000, 32'h0,         32'h00008001, 2, 0, 1, 8);
        tbl[9]  = mk(3'd6, 1'b1, 32'h700,       32'h0,       32'hCAFEF00D,  32'h0,        2, 1, 32'h700,      4'b1111, 32'hCAFEF00D,  32'h0,        4, 0, 0, 9);
        tbl[10] = mk(3'd1, 1'b0, 32'h800,       32'h3,       32'h0,         32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,         32'h0,        1, 1, 0, 10);
        tbl[11] = mk(3'd3, 1'b0, 32'h900,       32'h0,       32'h0,         32'h13572468, 1, 1, 32'h900,      4'b0000, 32'h0,         32'h13572468, 3, 0, 1, 11);
        tbl[12] = mk(3'd2, 1'b0, 32'hFFFFFFF0,  32'h14,      32'h0,         32'h0BADCAFE, 0, 1, 32'h4,        4'b0000, 32'h0,         32'h0BADCAFE, 2, 0, 1, 12);
        tbl[13] = mk(3'd4, 1'b1, 32'hA00,       32'h0,       32'h11223344,  32'h0,        0, 1, 32'hA00,      4'b1111, 32'h11223344,  32'h0,        2, 0, 0, 13);
        tbl[14] = mk(3'd0, 1'b0, 32'hB00,       32'h1,       32'h0,         32'h12345678, 0, 1, 32'hB00,      4'b0000, 32'h0,         32'h00000056, 2, 0, 1, 14);

        // Reset state, with reset still held.
        repeat (3) @(posedge clk_i);
        #1;
        check("rst.ready", 32'(issue_ready_o), 32'd1);
        check("rst.req", 32'(dmem_req_o), 32'd0);
        check("rst.addr", dmem_addr_o, 32'd0);
        check("rst.valid", 32'(result_valid_o), 32'd0);
        check("rst.result", result_o, 32'd0);
        check("rst.misalign", 32'(misalign_o), 32'd0);
        reset_i = 1'b0;
        @(posedge clk_i); #1;
        check("rst.ready_release", 32'(issue_ready_o), 32'd1);

        for (int i = 0; i < 15; i++) apply_vec(tbl[i], 1'b0, $sformatf("tbl%0d", i));

        // issue_valid held high across a misaligned op: no accept in RESP,
        // next op taken only after an idle cycle.
        src_op_1_i = 32'h100; imm_i = 32'h1; funct3_i = 3'd2; is_store_i = 1'b0;
        rrf_tag_i = 6'd33; pc_i = 32'h4000; dst_val_i = 1'b1;
        issue_valid_i = 1'b1;
        @(posedge clk_i); #1;
        check("hold.c1_valid", 32'(result_valid_o), 32'd1);
        check("hold.c1_misalign", 32'(misalign_o), 32'd1);
        check("hold.c1_ready", 32'(issue_ready_o), 32'd0);
        @(posedge clk_i); #1;
        check("hold.c2_valid", 32'(result_valid_o), 32'd0);
        check("hold.c2_ready", 32'(issue_ready_o), 32'd1);
        @(posedge clk_i); #1;
        issue_valid_i = 1'b0;
        check("hold.c3_valid", 32'(result_valid_o), 32'd1);
        @(posedge clk_i); #1;
        check("hold.c4_valid", 32'(result_valid_o), 32'd0);

        // Reset during an outstanding request; the late ack must be ignored.
        src_op_1_i = 32'h100; imm_i = 32'h8; funct3_i = 3'd2; is_store_i = 1'b0;
        issue_valid_i = 1'b1;
        @(posedge clk_i); #1;
        issue_valid_i = 1'b0;
        check("rreq.req", 32'(dmem_req_o), 32'd1);
        check("rreq.ready_busy", 32'(issue_ready_o), 32'd0);
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        check("rreq.req_cleared", 32'(dmem_req_o), 32'd0);
        check("rreq.addr_cleared", dmem_addr_o, 32'd0);
        check("rreq.ready_in_reset", 32'(issue_ready_o), 32'd1);
        reset_i = 1'b0;
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h5555AAAA;
        @(posedge clk_i); #1;
        dmem_ack_i = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (result_valid_o || dmem_req_o) seen = 1;
            @(posedge clk_i); #1;
        end
        check("rreq.no_result", 32'(seen), 32'd0);
        check("rreq.ready_after", 32'(issue_ready_o), 32'd1);

        // Randomized ops with spurious acks outside the request phase.
        for (int i = 0; i < 40; i++) begin
            rv.f3 = 3'($urandom_range(0, 7));
            rv.st = 1'($urandom_range(0, 1));
            rv.base = $urandom;
            rv.imm = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 64)) : $urandom;
            rv.data = $urandom;
            rv.rdata = $urandom;
            rv.pc = $urandom;
            rv.tag = 6'($urandom);
            rv.dv = 1'($urandom_range(0, 1));
            rv.delay = $urandom_range(0, 3);
            rv = model(rv);
            apply_vec(rv, 1'b1, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports (widths from Consts.vh macros): clk_i  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have reset_i  in  1  synchronous, active-high reset.
REQ-003 SHALL have issue_valid_i  in  1  memory-op entry issued by access-mem reservation station.
REQ-004 SHALL have inputs pc_i (ADDR_LEN), src_op_1_i (DATA_LEN, base), src_op_2_i (DATA_LEN, store data), imm_i (DATA_LEN), rrf_tag_i (RRF_SEL), dst_val_i (1), is_store_i (1), funct3_i (3, RV32I load/store width code).
REQ-005 SHALL have issue_ready_o  out  1  unit can accept an op this cycle.
REQ-006 SHALL have dmem_req_o, dmem_we_o  out  1 each, dmem_addr_o  out  ADDR_LEN, dmem_wdata_o  out  DATA_LEN, dmem_wstrb_o  out  4.
REQ-007 SHALL have dmem_ack_i  in  1  request completed, dmem_rdata_i  in  DATA_LEN  word-aligned read data valid with ack.
REQ-008 SHALL have result_valid_o  out  1, result_o  out  DATA_LEN, result_rrf_tag_o  out  RRF_SEL, result_dst_val_o  out  1, result_pc_o  out  ADDR_LEN, misalign_o  out  1.

Function
REQ-009 SHALL implement FSM states IDLE, REQ, RESP.
REQ-010 SHALL drive issue_ready_o = 1 only in IDLE; issue accepted when issue_valid_i & issue_ready_o.
REQ-011 On accept SHALL register addr = src_op_1_i + imm_i (mod 2^32), tag, dst_val, pc, store flag, funct3, store data.
REQ-012 Misalignment SHALL be: half (funct3[1:0]=01) with addr[0]=1, word (10) with addr[1:0]!=0; bytes never misaligned.
REQ-013 Aligned accept: IDLE->REQ; misaligned accept: IDLE->RESP with no memory request.
REQ-014 In REQ SHALL hold dmem_req_o=1 and all dmem_* outputs stable until the cycle dmem_ack_i=1; dmem_ack_i outside REQ SHALL be ignored.
REQ-015 dmem_addr_o SHALL be {addr[31:2],2'b00}; dmem_we_o = store flag.
REQ-016 Store strobes: SB 4'b0001<<addr[1:0], SH 4'b0011<<addr[1:0], SW 4'b1111; loads drive 4'b0000.
REQ-017 Store data: SB byte replicated x4, SH halfword replicated x2, SW as-is.
REQ-018 On ack in REQ SHALL capture load data shifted right by 8*addr[1:0] and extended: LB/LH sign, LBU/LHU zero, LW none; REQ->RESP.
REQ-019 In RESP SHALL assert result_valid_o for exactly one cycle, then RESP->IDLE; minimum aligned latency accept->result_valid_o = 2 cycles (ack in first REQ cycle).
REQ-020 result_o SHALL be load data for loads, 0 for stores and misaligned ops; result_dst_val_o = registered dst_val & ~store & ~misalign.
REQ-021 misalign_o SHALL equal 1 only in RESP of a misaligned op.
REQ-022 Outside RESP, result_valid_o and misalign_o SHALL be 0; other result_* hold last values.
REQ-023 Unsupported funct3 (011, 110, 111, or store with funct3[2]=1) SHALL be treated as word width.
REQ-024 Back-to-back ops SHALL be separated by at least one IDLE cycle; no op accepted in RESP.

Reset
REQ-025 reset_i SHALL force IDLE and zero every output and internal register on the next edge, overriding an in-flight request.
REQ-026 dmem_ack_i arriving after reset mid-REQ SHALL be ignored and produce no result.
REQ-027 During reset issue_ready_o SHALL be 0 only when the FSM is not yet IDLE; after reset release, issue_ready_o = 1.

Verification
REQ-028 LW base 0x100 imm 0x4, ack next cycle rdata 0xDEADBEEF -> dmem_addr_o 0x104, result_o 0xDEADBEEF, result_valid_o 2 cycles after accept.
REQ-029 LB addr 0x203, rdata 0x80AABBCC -> result_o 0xFFFFFF80; LBU same -> 0x00000080.
REQ-030 SH addr 0x302 data 0x1234ABCD -> wstrb 4'b1100, wdata 0xABCDABCD, we=1, result_dst_val_o 0.
REQ-031 LW addr 0x101 -> no dmem_req_o, misalign_o=1 with result_valid_o 1 cycle after accept.
REQ-032 ack delayed 3 cycles -> dmem_req_o and addr stable 4 cycles, issue_ready_o 0 throughout, single result pulse.
REQ-033 reset asserted during REQ, ack next cycle -> no result_valid_o, issue_ready_o 1 after release.
